// File: rtl/edge_filter_ctrl_if.sv
// Pixel, filter, output and configuration signals of the Sobel edge filter sequencer.
// The master side is the environment (source, filter, sink); the slave side is the controller.
interface edge_filter_ctrl_if;
   logic        pix_valid;
   logic        pix_sof;
   logic [11:0] pix_data;
   logic        filt_ready;
   logic [11:0] filt_video_in;
   logic [11:0] filt_video_out;
   logic        out_valid;
   logic        out_sof;
   logic [11:0] out_data;
   logic        cfg_valid;
   logic [1:0]  cfg_mode;
   logic        cfg_ready;
   logic [1:0]  mode_active;
   logic        frame_done;
   logic        frame_err;

   modport master (
      output pix_valid, pix_sof, pix_data, filt_video_out, cfg_valid, cfg_mode,
      input  filt_ready, filt_video_in, out_valid, out_sof, out_data,
             cfg_ready, mode_active, frame_done, frame_err
   );

   modport slave (
      input  pix_valid, pix_sof, pix_data, filt_video_out, cfg_valid, cfg_mode,
      output filt_ready, filt_video_in, out_valid, out_sof, out_data,
             cfg_ready, mode_active, frame_done, frame_err
   );
endinterface

// File: rtl/edge_filter_ctrl.sv
// Sequencer for the Sobel edge filter: frames the RGB444 stream, tracks pixel position,
// masks border windows and applies output-mode changes only at frame boundaries.
module edge_filter_ctrl #(
   parameter int WIDTH  = 640,
   parameter int HEIGHT = 480
) (
   input logic               clk,
   input logic               reset,
   edge_filter_ctrl_if.slave bus
);

   localparam int XW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
   localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      WAIT_SOF = 2'd2
   } state_t;

   typedef enum logic [1:0] {
      MODE_BYPASS  = 2'd0,
      MODE_EDGE    = 2'd1,
      MODE_OVERLAY = 2'd2,
      MODE_BLANK   = 2'd3
   } mode_t;

   state_t        state, state_next;
   logic [XW-1:0] x_cnt, x_next, cur_x;
   logic [YW-1:0] y_cnt, y_next, cur_y;
   mode_t         mode_reg, eff_mode, pend_mode;
   logic          pend_valid;

   logic          accept;
   logic          last_pix;
   logic          early_sof;
   logic          drop_err;
   logic          cfg_fire;
   logic          apply_cfg;
   logic          border;
   logic [11:0]   data_sel;

   logic          out_valid_q;
   logic          out_sof_q;
   logic [11:0]   out_data_q;
   logic          frame_done_q;
   logic          frame_err_q;

   // x_cnt/y_cnt hold the position the next non-SOF pixel will take; an SOF pixel is always (0,0).
   always_comb begin
      accept    = bus.pix_valid & ((state == RUN) | bus.pix_sof);
      cur_x     = bus.pix_sof ? '0 : x_cnt;
      cur_y     = bus.pix_sof ? '0 : y_cnt;
      last_pix  = (cur_x == XW'(WIDTH - 1)) && (cur_y == YW'(HEIGHT - 1));
      early_sof = accept & bus.pix_sof & (state == RUN) & ((x_cnt != '0) | (y_cnt != '0));
      drop_err  = (state == WAIT_SOF) & bus.pix_valid & ~bus.pix_sof;
      cfg_fire  = bus.cfg_valid & ~pend_valid;
      apply_cfg = accept & bus.pix_sof & pend_valid;
      eff_mode  = apply_cfg ? pend_mode : mode_reg;
      border    = (int'(cur_x) < 2) || (int'(cur_y) < 2);
   end

   always_comb begin
      x_next = x_cnt;
      y_next = y_cnt;
      if (accept) begin
         if (cur_x == XW'(WIDTH - 1)) begin
            x_next = '0;
            y_next = (cur_y == YW'(HEIGHT - 1)) ? '0 : cur_y + YW'(1);
         end else begin
            x_next = cur_x + XW'(1);
            y_next = cur_y;
         end
      end
   end

   // Accepting cycles only reach IDLE/WAIT_SOF with an SOF, so one rule covers every state.
   always_comb begin
      state_next = state;
      case (state)
         IDLE, RUN, WAIT_SOF: begin
            if (accept) begin
               state_next = last_pix ? WAIT_SOF : RUN;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      data_sel = 12'h000;
      case (eff_mode)
         MODE_BYPASS:  data_sel = bus.pix_data;
         MODE_EDGE:    data_sel = border ? 12'h000 : bus.filt_video_out;
         MODE_OVERLAY: data_sel = (!border && bus.filt_video_out != 12'h000) ? bus.filt_video_out
                                                                             : bus.pix_data;
         MODE_BLANK:   data_sel = 12'h000;
         default:      data_sel = 12'h000;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         x_cnt <= '0;
         y_cnt <= '0;
      end else begin
         state <= state_next;
         x_cnt <= x_next;
         y_cnt <= y_next;
      end
   end

   // A request landing in the same cycle as an applied SOF cannot occur: cfg_ready is low then.
   always_ff @(posedge clk) begin
      if (reset) begin
         mode_reg   <= MODE_BYPASS;
         pend_mode  <= MODE_BYPASS;
         pend_valid <= 1'b0;
      end else begin
         mode_reg <= eff_mode;
         if (cfg_fire) begin
            pend_valid <= 1'b1;
            pend_mode  <= mode_t'(bus.cfg_mode);
         end else if (apply_cfg) begin
            pend_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q  <= 1'b0;
         out_sof_q    <= 1'b0;
         out_data_q   <= 12'h000;
         frame_done_q <= 1'b0;
         frame_err_q  <= 1'b0;
      end else begin
         out_valid_q  <= accept;
         out_sof_q    <= accept & bus.pix_sof;
         if (accept) begin
            out_data_q <= data_sel;
         end
         frame_done_q <= accept & last_pix;
         frame_err_q  <= early_sof | drop_err;
      end
   end

   assign bus.filt_ready    = accept;
   assign bus.filt_video_in = bus.pix_data;
   assign bus.cfg_ready     = ~pend_valid;
   assign bus.mode_active   = eff_mode;
   assign bus.out_valid     = out_valid_q;
   assign bus.out_sof       = out_sof_q;
   assign bus.out_data      = out_data_q;
   assign bus.frame_done    = frame_done_q;
   assign bus.frame_err     = frame_err_q;

endmodule

// File: tb/tb_edge_filter_ctrl.sv
// Directed vector bench for edge_filter_ctrl on a 4x3 frame: one record per clock cycle,
// combinational outputs checked before the edge, registered outputs just after it.
module tb_edge_filter_ctrl;
   localparam int W = 4;
   localparam int H = 3;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   edge_filter_ctrl_if bus ();

   edge_filter_ctrl #(.WIDTH(W), .HEIGHT(H)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      string       name;
      logic        rst, pv, sof;
      logic [11:0] pd, fvo;
      logic        cv;
      logic [1:0]  cm;
      logic        e_fr, e_crdy;
      logic [1:0]  e_mode;
      logic        e_ov, e_osof;
      logic [11:0] e_od;
      logic        chk_od, e_done, e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t v(input string name, input logic rst, pv, sof,
                              input logic [11:0] pd, fvo, input logic cv, input logic [1:0] cm,
                              input logic e_fr, e_crdy, input logic [1:0] e_mode,
                              input logic e_ov, e_osof, input logic [11:0] e_od,
                              input logic chk_od, e_done, e_err);
      vec_t t;
      t.name = name; t.rst = rst; t.pv = pv; t.sof = sof; t.pd = pd; t.fvo = fvo;
      t.cv = cv; t.cm = cm; t.e_fr = e_fr; t.e_crdy = e_crdy; t.e_mode = e_mode;
      t.e_ov = e_ov; t.e_osof = e_osof; t.e_od = e_od; t.chk_od = chk_od;
      t.e_done = e_done; t.e_err = e_err;
      return t;
   endfunction

   task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t t);
      @(negedge clk);
      reset              = t.rst;
      bus.pix_valid      = t.pv;
      bus.pix_sof        = t.sof;
      bus.pix_data       = t.pd;
      bus.filt_video_out = t.fvo;
      bus.cfg_valid      = t.cv;
      bus.cfg_mode       = t.cm;
      #1;
      checkOutput({t.name, " filt_ready"}, 12'(bus.filt_ready), 12'(t.e_fr));
      checkOutput({t.name, " cfg_ready"}, 12'(bus.cfg_ready), 12'(t.e_crdy));
      checkOutput({t.name, " mode_active"}, 12'(bus.mode_active), 12'(t.e_mode));
      if (t.e_fr) checkOutput({t.name, " filt_video_in"}, bus.filt_video_in, t.pd);
      @(posedge clk);
      #1;
      checkOutput({t.name, " out_valid"}, 12'(bus.out_valid), 12'(t.e_ov));
      checkOutput({t.name, " out_sof"}, 12'(bus.out_sof), 12'(t.e_osof));
      checkOutput({t.name, " frame_done"}, 12'(bus.frame_done), 12'(t.e_done));
      checkOutput({t.name, " frame_err"}, 12'(bus.frame_err), 12'(t.e_err));
      if (t.chk_od) checkOutput({t.name, " out_data"}, bus.out_data, t.e_od);
   endtask

   // Early SOF at (2,1) while a blank request is pending: frame restarts, no done for the cut frame.
   task automatic seqEarlySof();
      applyStimulus(v("ea_req", 0, 0, 0, 12'h000, 12'h000, 1, 2'b01, 0, 1, 2'b10, 0, 0, 12'h000, 0, 0, 0));
      for (int i = 0; i < 6; i++)
         applyStimulus(v($sformatf("ea_pix[%0d]", i), 0, 1, i == 0, 12'h123, 12'hFFF, i == 5, 2'b11,
                         1, i != 0, 2'b01, 1, i == 0, 12'h000, 1, 0, 0));
      applyStimulus(v("ea_sof", 0, 1, 1, 12'h123, 12'hFFF, 0, 2'b00, 1, 0, 2'b11, 1, 1, 12'h000, 1, 0, 1));
      for (int j = 0; j < 11; j++)
         applyStimulus(v($sformatf("ea_rest[%0d]", j), 0, 1, 0, 12'h200 + 12'(j), 12'hFFF, 0, 2'b00,
                         1, 1, 2'b11, 1, 0, 12'h000, 1, j == 10, 0));
   endtask

   // Reset in mid-frame with a pending blank request: request discarded, next frame in bypass.
   task automatic seqResetMidFrame();
      applyStimulus(v("rm_sof", 0, 1, 1, 12'h777, 12'h000, 0, 2'b00, 1, 1, 2'b11, 1, 1, 12'h000, 1, 0, 0));
      applyStimulus(v("rm_req", 0, 1, 0, 12'h778, 12'h000, 1, 2'b11, 1, 1, 2'b11, 1, 0, 12'h000, 1, 0, 0));
      applyStimulus(v("rm_pend", 0, 1, 0, 12'h779, 12'h000, 0, 2'b00, 1, 0, 2'b11, 1, 0, 12'h000, 1, 0, 0));
      applyStimulus(v("rm_reset", 1, 0, 0, 12'h000, 12'h000, 0, 2'b00, 0, 0, 2'b11, 0, 0, 12'h000, 1, 0, 0));
      applyStimulus(v("rm_nosof", 0, 1, 0, 12'h888, 12'h000, 0, 2'b00, 0, 1, 2'b00, 0, 0, 12'h000, 0, 0, 0));
      applyStimulus(v("rm_new0", 0, 1, 1, 12'h456, 12'hABC, 0, 2'b00, 1, 1, 2'b00, 1, 1, 12'h456, 1, 0, 0));
      applyStimulus(v("rm_new1", 0, 1, 0, 12'h457, 12'hABC, 0, 2'b00, 1, 1, 2'b00, 1, 0, 12'h457, 1, 0, 0));
      applyStimulus(v("rm_hold", 0, 0, 0, 12'h000, 12'hABC, 0, 2'b00, 0, 1, 2'b00, 0, 0, 12'h457, 1, 0, 0));
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "[TB] timeout");
   end

   initial begin
      int          x, y;
      logic [11:0] fvo, od;

      bus.pix_valid      = 1'b0;
      bus.pix_sof        = 1'b0;
      bus.pix_data       = 12'h000;
      bus.filt_video_out = 12'h000;
      bus.cfg_valid      = 1'b0;
      bus.cfg_mode       = 2'b00;
      repeat (2) @(posedge clk);

      // Reset state and pixels without SOF after reset are dropped silently.
      vecs.push_back(v("reset", 1, 0, 0, 12'h000, 12'h000, 0, 2'b00, 0, 1, 2'b00, 0, 0, 12'h000, 1, 0, 0));
      for (int i = 0; i < 3; i++)
         vecs.push_back(v($sformatf("idle_drop[%0d]", i), 0, 1, 0, 12'h111, 12'h000, 0, 2'b00,
                          0, 1, 2'b00, 0, 0, 12'h000, 0, 0, 0));

      // Bypass frame 0x001..0x00C with an edge-mode request at the fifth pixel.
      for (int i = 0; i < W * H; i++)
         vecs.push_back(v($sformatf("byp[%0d]", i), 0, 1, i == 0, 12'(i + 1), 12'hFFF, i == 4, 2'b01,
                          1, i <= 4, 2'b00, 1, i == 0, 12'(i + 1), 1, i == W * H - 1, 0));
      vecs.push_back(v("wait_idle", 0, 0, 0, 12'h000, 12'h000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 12'h000, 0, 0, 0));
      vecs.push_back(v("wait_drop", 0, 1, 0, 12'h0EE, 12'h000, 0, 2'b00, 0, 0, 2'b00, 0, 0, 12'h000, 0, 0, 1));

      // Edge frame with filter output 0xFFF and a one-cycle gap after (1,1).
      for (int i = 0; i < W * H; i++) begin
         x  = i % W;
         y  = i / W;
         od = (x < 2 || y < 2) ? 12'h000 : 12'hFFF;
         vecs.push_back(v($sformatf("edge[%0d]", i), 0, 1, i == 0, 12'h100 + 12'(i), 12'hFFF, 0, 2'b00,
                          1, i != 0, 2'b01, 1, i == 0, od, 1, i == W * H - 1, 0));
         if (i == 5)
            vecs.push_back(v("edge_gap", 0, 0, 0, 12'h000, 12'hFFF, 0, 2'b00,
                             0, 1, 2'b01, 0, 0, 12'h000, 0, 0, 0));
      end

      // Overlay frame: pix 0x5A3, filter 0x888 except 0x000 at (2,2).
      vecs.push_back(v("ovl_req", 0, 0, 0, 12'h000, 12'h000, 1, 2'b10, 0, 1, 2'b01, 0, 0, 12'h000, 0, 0, 0));
      for (int i = 0; i < W * H; i++) begin
         x   = i % W;
         y   = i / W;
         fvo = (x == 2 && y == 2) ? 12'h000 : 12'h888;
         od  = (x < 2 || y < 2 || fvo == 12'h000) ? 12'h5A3 : fvo;
         vecs.push_back(v($sformatf("ovl[%0d]", i), 0, 1, i == 0, 12'h5A3, fvo, 0, 2'b00,
                          1, i != 0, 2'b10, 1, i == 0, od, 1, i == W * H - 1, 0));
      end

      foreach (vecs[k]) applyStimulus(vecs[k]);

      seqEarlySof();
      seqResetMidFrame();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
